// File: rtl/count_sequencer.sv
// Moore controller that drives a 3-bit clear-and-count datapath through PASSES passes
// with a start/busy/done handshake, abort and a COUNT-phase watchdog.
module count_sequencer #(
  parameter int unsigned PASSES  = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       status,
  output logic       t0,
  output logic       t1,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] pass_cnt
);

  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_COUNT = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  localparam logic [CNT_W-1:0] PASSES_V = CNT_W'(PASSES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] tmo;
  logic [CNT_W-1:0] tmo_nxt;
  logic [CNT_W-1:0] pass_nxt;
  logic [CNT_W-1:0] pass_inc;

  // State, counters and Moore outputs; outputs are registered from the next-state
  // decode so they always match the state register and clear with it on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      tmo      <= '0;
      pass_cnt <= '0;
      t0       <= 1'b0;
      t1       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      tmo      <= tmo_nxt;
      pass_cnt <= pass_nxt;
      t0       <= (state_nxt == S_CLEAR);
      t1       <= (state_nxt == S_COUNT);
      busy     <= (state_nxt == S_CLEAR) || (state_nxt == S_COUNT) || (state_nxt == S_CHECK);
      done     <= (state_nxt == S_DONE);
      err      <= (state_nxt == S_ERROR);
    end
  end

  // Next-state and counter update; abort beats status, status beats the watchdog.
  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo;
    pass_nxt  = pass_cnt;
    pass_inc  = pass_cnt + CNT_W'(1);

    case (state)
      S_IDLE: begin
        pass_nxt = '0;
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_COUNT;
          tmo_nxt   = '0;
        end
      end
      S_COUNT: begin
        tmo_nxt = tmo + CNT_W'(1);
        // status in the first COUNT cycle still reflects the pre-clear register
        if (abort)                          state_nxt = S_IDLE;
        else if (status && (tmo != '0))     state_nxt = S_CHECK;
        else if (tmo == TMO_LAST)           state_nxt = S_ERROR;
      end
      S_CHECK: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          pass_nxt  = pass_inc;
          state_nxt = (pass_inc == PASSES_V) ? S_DONE : S_CLEAR;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      S_ERROR: begin
        if (start) begin
          state_nxt = S_CLEAR;
          pass_nxt  = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (state_nxt == S_IDLE) pass_nxt = '0;
  end

endmodule
